multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. Sequences instruction fetch, decode, execute, memory access and write-back around the shared ALU, register file, instruction/data memory ports and immediate generator. Decodes opcode/funct fields of the instruction register and drives every datapath strobe and mux select. Detects illegal opcodes and memory-port timeouts, then halts in a trap state.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before bus error (≥2)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
inst_code  input  32  current instruction register contents
branch_taken  input  1  ALU comparison result for current branch
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
imem_req  output  1  instruction fetch request
ir_we  output  1  latch fetched word into instruction register
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (valid only with dmem_req)
alu_src_b  output  1  0 = rs2, 1 = immediate
alu_op  output  2  0 add, 1 branch compare, 2 funct3/funct7 decode
rf_we  output  1  register file write enable
wb_sel  output  2  0 ALU, 1 memory data, 2 PC+4, 3 immediate
pc_we  output  1  PC update strobe
pc_src  output  2  0 PC+4, 1 PC+imm, 2 ALU result with bit0 cleared
instret  output  1  one-cycle pulse per retired instruction
illegal  output  1  sticky: unsupported opcode trapped
bus_err  output  1  sticky: memory timeout trapped
state_o  output  3  current state encoding, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- Reset: while reset low and in the first cycle after release, state=IDLE and every output=0. IDLE→FETCH unconditionally. Reset asserted mid-instruction aborts immediately; no strobe completes.
- FETCH: imem_req=1 each cycle. Cycle where imem_ready=1: ir_we=1, go DECODE. Otherwise stay.
- DECODE: 1 cycle, no strobes. Supported opcodes: 0000011 load, 0010011 op-imm, 0110011 op, 1100111 jalr, 0110111 lui, 0100011 store, 1100011 branch, 1101111 jal. Any other opcode → TRAP, illegal set.
- EXEC: alu_src_b=1 for all opcodes except op and branch. alu_op=2 for op/op-imm, 1 for branch, 0 otherwise.
  - Branch: last cycle. pc_we=1, pc_src=branch_taken?1:0, instret=1 → FETCH.
  - Load/store → MEM. All others → WB.
- MEM: dmem_req=1; dmem_we=1 for store. Cycle where dmem_ready=1:
  - Store: pc_we=1, pc_src=0, instret=1 → FETCH.
  - Load: → WB.
- WB: rf_we=1, pc_we=1, instret=1 → FETCH.
  - wb_sel: 1 load, 3 lui, 2 jal/jalr, 0 op/op-imm.
  - pc_src: 1 jal, 2 jalr, 0 otherwise.
- Zero-wait latencies: branch 3 cycles; store, op, op-imm, lui, jal, jalr 4 cycles; load 5 cycles.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each cycle the request is high with ready low. If ready is still low in the MEM_TIMEOUT-th request cycle → TRAP, bus_err set, and no ir_we/pc_we in that cycle. Ready high in that same cycle wins; no error.
- TRAP: all strobes 0, state_o=7. Left only by reset; illegal and bus_err clear only on reset.
- Ready inputs outside their request states are ignored.
- Strobes are combinational from the registered state plus the ready inputs/branch_taken. State, counter and flags are the only registers.

Test Plan:
- Reset held low 3 cycles, release with imem_ready=1 and inst_code=0x00500093 (addi): state sequence 0,1,2,3,5,1; ir_we in cycle 2, rf_we/pc_we/instret in cycle 5, alu_src_b=1, wb_sel=0.
- Load 0x0000A103 with dmem_ready low 3 MEM cycles: dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=1; instret exactly once.
- Branch 0x00208463 with branch_taken=1, then 0: pc_src=1, then 0; pc_we and instret in EXEC; no rf_we; 3 cycles each.
- JAL 0x008000EF: WB wb_sel=2, pc_src=1. JALR 0x000080E7: pc_src=2. LUI 0x123450B7: wb_sel=3.
- inst_code=0x0000007F: DECODE → TRAP; illegal=1; all strobes 0 for 20 cycles; reset clears.
- MEM_TIMEOUT=4, imem_ready held 0: imem_req high 4 cycles, then TRAP with bus_err=1. Repeat with ready high in 4th cycle: no error, ir_we=1.
- Reset asserted during MEM of a store: outputs 0 immediately, dmem_we never seen with pc_we; restart at IDLE.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: branch 3 cycles, store/ALU/jump/lui 4, load 5 (zero-wait).
// Stalls in FETCH/MEM while the memory port is not ready; traps after MEM_TIMEOUT request cycles.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_code,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        instret,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          ill_q;
    logic          berr_q;

    logic [6:0] opcode;
    logic       is_load, is_imm, is_reg, is_jalr, is_lui, is_store, is_branch, is_jal;
    logic       op_legal;
    logic       fetch_stall, mem_stall;
    logic       fetch_timeout, mem_timeout;
    logic       unused_inst;

    // Only the opcode steers sequencing; funct fields are decoded by the ALU itself.
    assign opcode      = inst_code[6:0];
    assign unused_inst = ^inst_code[31:7];

    assign is_load   = (opcode == OP_LOAD);
    assign is_imm    = (opcode == OP_IMM);
    assign is_reg    = (opcode == OP_REG);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign op_legal  = is_load | is_imm | is_reg | is_jalr | is_lui | is_store | is_branch | is_jal;

    assign fetch_stall   = (state == S_FETCH) && !imem_ready;
    assign mem_stall     = (state == S_MEM) && !dmem_ready;
    assign fetch_timeout = fetch_stall && (wait_cnt == WAIT_LAST);
    assign mem_timeout   = mem_stall && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'd0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        instret   = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (fetch_timeout) begin
                    state_nxt = S_TRAP;
                end
            end
            S_DECODE: state_nxt = op_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_src_b = !(is_reg || is_branch);
                if (is_reg || is_imm)
                    alu_op = 2'd2;
                else if (is_branch)
                    alu_op = 2'd1;
                if (is_branch) begin
                    pc_we     = 1'b1;
                    pc_src    = branch_taken ? 2'd1 : 2'd0;
                    instret   = 1'b1;
                    state_nxt = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_we     = 1'b1;
                        instret   = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (mem_timeout) begin
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                instret = 1'b1;
                if (is_load)
                    wb_sel = 2'd1;
                else if (is_lui)
                    wb_sel = 2'd3;
                else if (is_jal || is_jalr)
                    wb_sel = 2'd2;
                if (is_jal)
                    pc_src = 2'd1;
                else if (is_jalr)
                    pc_src = 2'd2;
                state_nxt = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_TRAP;
        endcase
    end

    // The wait counter is zero whenever no request is stalling, which covers entry to FETCH/MEM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            ill_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch_stall || mem_stall)
                wait_cnt <= wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
            if (state == S_DECODE && !op_legal)
                ill_q <= 1'b1;
            if (fetch_timeout || mem_timeout)
                berr_q <= 1'b1;
        end
    end

    assign illegal = ill_q;
    assign bus_err = berr_q;
    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into an expected
// per-cycle output trace from the sequencing rules, then replayed against the DUT.
module tb_multicycle_ctrl;

    localparam int T = 4;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       instret;
        logic       illegal;
        logic       bus_err;
        logic [2:0] state;
    } out_t;

    typedef struct {
        logic [31:0] ic;
        logic        imr;
        logic        dmr;
        logic        bt;
        out_t        exp;
    } step_t;

    logic        clk;
    logic        reset;
    logic [31:0] inst_code;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_we, dmem_req, dmem_we, alu_src_b, rf_we, pc_we, instret;
    logic        illegal, bus_err;
    logic [1:0]  alu_op, wb_sel, pc_src;
    logic [2:0]  state_o;
    out_t        obs;

    multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .inst_code(inst_code), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src), .instret(instret),
        .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
    );

    assign obs = {imem_req, ir_we, dmem_req, dmem_we, alu_src_b, alu_op, rf_we, wb_sel,
                  pc_we, pc_src, instret, illegal, bus_err, state_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    logic  m_ill  = 1'b0;
    logic  m_berr = 1'b0;
    step_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic out_t mk(input logic [2:0] st);
        out_t o;
        o         = '0;
        o.state   = st;
        o.illegal = m_ill;
        o.bus_err = m_berr;
        return o;
    endfunction

    task automatic push(input logic [31:0] ic, input logic imr, input logic dmr,
                        input logic bt, input out_t e);
        step_t s;
        s.ic = ic; s.imr = imr; s.dmr = dmr; s.bt = bt; s.exp = e;
        q.push_back(s);
    endtask

    // Expected trace for one instruction; iw/dw are the not-ready cycles before each port answers.
    task automatic add_instr(input logic [31:0] inst, input int iw, input int dw,
                             input logic bt, output bit trapped);
        logic [6:0] opc;
        bit   ld, st, rr, im, jl, jr, lu, br;
        out_t e;
        opc = inst[6:0];
        ld = (opc == 7'h03); st = (opc == 7'h23); rr = (opc == 7'h33); im = (opc == 7'h13);
        jl = (opc == 7'h6F); jr = (opc == 7'h67); lu = (opc == 7'h37); br = (opc == 7'h63);
        trapped = 1'b0;
        for (int k = 0; k < iw && k < T; k++) begin
            e = mk(3'd1); e.imem_req = 1'b1;
            push($urandom, 1'b0, rb(), rb(), e);
        end
        if (iw >= T) begin
            m_berr = 1'b1; trapped = 1'b1; return;
        end
        e = mk(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1;
        push($urandom, 1'b1, rb(), rb(), e);
        push(inst, rb(), rb(), rb(), mk(3'd2));
        if (!(ld || st || rr || im || jl || jr || lu || br)) begin
            m_ill = 1'b1; trapped = 1'b1; return;
        end
        e = mk(3'd3);
        e.alu_src_b = !(rr || br);
        e.alu_op    = (rr || im) ? 2'd2 : (br ? 2'd1 : 2'd0);
        if (br) begin
            e.pc_we = 1'b1; e.instret = 1'b1; e.pc_src = bt ? 2'd1 : 2'd0;
            push(inst, rb(), rb(), bt, e);
            return;
        end
        push(inst, rb(), rb(), rb(), e);
        if (ld || st) begin
            for (int k = 0; k < dw && k < T; k++) begin
                e = mk(3'd4); e.dmem_req = 1'b1; e.dmem_we = st;
                push(inst, rb(), 1'b0, rb(), e);
            end
            if (dw >= T) begin
                m_berr = 1'b1; trapped = 1'b1; return;
            end
            e = mk(3'd4); e.dmem_req = 1'b1; e.dmem_we = st;
            if (st) begin
                e.pc_we = 1'b1; e.instret = 1'b1;
            end
            push(inst, rb(), 1'b1, rb(), e);
            if (st) return;
        end
        e = mk(3'd5); e.rf_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
        e.wb_sel = ld ? 2'd1 : (lu ? 2'd3 : ((jl || jr) ? 2'd2 : 2'd0));
        e.pc_src = jl ? 2'd1 : (jr ? 2'd2 : 2'd0);
        push(inst, rb(), rb(), rb(), e);
    endtask

    task automatic run_q(input int limit);
        step_t s;
        int    n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            s = q.pop_front();
            @(negedge clk);
            inst_code = s.ic; imem_ready = s.imr; dmem_ready = s.dmr; branch_taken = s.bt;
            #2;
            check($sformatf("cyc%0d_st%0d", cyc, s.exp.state), {13'd0, obs}, {13'd0, s.exp});
            cyc++;
            n++;
        end
    endtask

    task automatic trap_tail(input int n);
        for (int k = 0; k < n; k++) push($urandom, rb(), rb(), rb(), mk(3'd7));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0; m_ill = 1'b0; m_berr = 1'b0;
        imem_ready = rb(); dmem_ready = rb();
        #1 check("rst_assert", {13'd0, obs}, 32'd0);
        repeat (n) begin
            @(negedge clk);
            #1 check("rst_hold", {13'd0, obs}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_idle", {13'd0, obs}, 32'd0);
    endtask

    task automatic one(input logic [31:0] inst, input int iw, input int dw, input logic bt,
                       input int tail);
        bit tr;
        add_instr(inst, iw, dw, bt, tr);
        if (tr) trap_tail(tail);
        run_q(1000);
        if (tr) do_reset(1);
    endtask

    logic [6:0] legal_ops [8] = '{7'h03, 7'h13, 7'h33, 7'h67, 7'h37, 7'h23, 7'h63, 7'h6F};

    initial begin
        logic [31:0] r;
        logic [31:0] inst;
        int          iw, dw;
        reset = 1'b1; inst_code = '0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        #1;
        do_reset(3);
        one(32'h00500093, 0, 0, 1'b0, 0);
        one(32'h0000A103, 0, 3, 1'b0, 0);
        one(32'h00208463, 0, 0, 1'b1, 0);
        one(32'h00208463, 0, 0, 1'b0, 0);
        one(32'h008000EF, 0, 0, 1'b0, 0);
        one(32'h000080E7, 0, 0, 1'b0, 0);
        one(32'h123450B7, 0, 0, 1'b0, 0);
        one(32'h0020A023, 1, 2, 1'b0, 0);
        one(32'h002081B3, 2, 0, 1'b0, 0);
        one(32'h0000007F, 0, 0, 1'b0, 20);
        one(32'h00500093, T, 0, 1'b0, 5);
        one(32'h00500093, T - 1, 0, 1'b0, 0);
        one(32'h0000A103, 0, T, 1'b0, 5);
        one(32'h0020A023, 0, T - 1, 1'b0, 0);

        // Abort a store while it waits in MEM, with dmem_ready rising as reset hits.
        begin
            bit tr;
            add_instr(32'h0020A023, 0, 3, 1'b0, tr);
            run_q(5);
            q.delete();
            @(negedge clk);
            inst_code = 32'h0020A023; dmem_ready = 1'b1; reset = 1'b0;
            #1 check("abort_store", {13'd0, obs}, 32'd0);
            do_reset(1);
        end
        one(32'h00500093, 0, 0, 1'b0, 0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom;
            if ($urandom_range(0, 19) == 0)
                inst = {r[31:7], 7'($urandom)};
            else
                inst = {r[31:7], legal_ops[$urandom_range(0, 7)]};
            iw = ($urandom_range(0, 24) == 0) ? T + 1 : $urandom_range(0, T - 1);
            dw = ($urandom_range(0, 24) == 0) ? T : $urandom_range(0, T - 1);
            one(inst, iw, dw, rb(), $urandom_range(1, 6));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
